mem_request_sequencer: RTL and testbench

Load/store front end sitting directly upstream of the memory-mapped register banks and RAMs. It accepts one load or store from the core over a valid/ready handshake and drives it onto the peripheral request bus (address, write data, write enable, count) for exactly one cycle. It then waits for the registered response, sign- or zero-extends load data, and returns the data plus memory code to the core. A timeout guards against unmapped or silent slaves.

---
 rtl/mem_request_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mem_request_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_sequencer.sv
// Load/store front end: one command in, one peripheral request out, one extended response back.
// The timeout counter bounds the wait for slaves that never answer.
`ifndef MEM_BUS_DEFS
`define MEM_BUS_DEFS
`define ADDR_W 32
`define WORD_W 32
`define MEM_COUNT_W 3
`define MEM_COUNT_NONE 3'd0
`define MEM_COUNT_BYTE 3'd1
`define MEM_COUNT_HALF 3'd2
`define MEM_COUNT_WORD 3'd3
`define MEM_CODE_W 3
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module mem_request_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 8,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [`ADDR_W-1:0]      i_cmd_addr,
   input  logic [`WORD_W-1:0]      i_cmd_wr_data,
   input  logic                    i_cmd_wr_en,
   input  logic [`MEM_COUNT_W-1:0] i_cmd_count,
   input  logic                    i_cmd_unsigned,
   output logic [`ADDR_W-1:0]      o_req_addr,
   output logic [`WORD_W-1:0]      o_req_wr_data,
   output logic                    o_req_wr_en,
   output logic [`MEM_COUNT_W-1:0] o_req_count,
   input  logic [`WORD_W-1:0]      i_res_rd_data,
   input  logic [`MEM_CODE_W-1:0]  i_res_code,
   output logic                    o_rsp_valid,
   output logic [`WORD_W-1:0]      o_rsp_rd_data,
   output logic [`MEM_CODE_W-1:0]  o_rsp_code,
   output logic                    o_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [`ADDR_W-1:0]      addr_q, addr_d;
   logic [`WORD_W-1:0]      wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic [`MEM_COUNT_W-1:0] count_q, count_d;
   logic                    uns_q, uns_d;
   logic [`WORD_W-1:0]      rdata_q, rdata_d;
   logic [`MEM_CODE_W-1:0]  code_q, code_d;
   logic                    tmo_q, tmo_d;

   function automatic logic count_ok(input logic [`MEM_COUNT_W-1:0] c);
      return (c == `MEM_COUNT_BYTE) || (c == `MEM_COUNT_HALF) || (c == `MEM_COUNT_WORD);
   endfunction

   function automatic logic [`WORD_W-1:0] extend(input logic [`WORD_W-1:0] d,
                                                 input logic [`MEM_COUNT_W-1:0] c,
                                                 input logic uns);
      case (c)
         `MEM_COUNT_BYTE: extend = {{(`WORD_W-8){~uns & d[7]}}, d[7:0]};
         `MEM_COUNT_HALF: extend = {{(`WORD_W-16){~uns & d[15]}}, d[15:0]};
         default:         extend = d;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         code_q  <= `MEM_CODE_INVALID;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         code_q  <= code_d;
         tmo_q   <= tmo_d;
      end
   end

   // Latched command copy; only meaningful while a transaction is in flight.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      count_q <= count_d;
      uns_q   <= uns_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      count_d = count_q;
      uns_d   = uns_q;
      rdata_d = rdata_q;
      code_d  = code_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               addr_d  = i_cmd_addr;
               wdata_d = i_cmd_wr_data;
               we_d    = i_cmd_wr_en;
               count_d = i_cmd_count;
               uns_d   = i_cmd_unsigned;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d = '0;
            if (count_ok(count_q)) begin
               state_d = S_WAIT;
            end else begin
               rdata_d = '0;
               code_d  = `MEM_CODE_INVALID;
               tmo_d   = 1'b0;
               state_d = S_RESP;
            end
         end
         S_WAIT: begin
            if (i_res_code != `MEM_CODE_INVALID) begin
               code_d  = i_res_code;
               rdata_d = (i_res_code == `MEM_CODE_READ) ? extend(i_res_rd_data, count_q, uns_q) : '0;
               tmo_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               code_d  = `MEM_CODE_OUT_OF_BOUNDS;
               rdata_d = '0;
               tmo_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_cmd_ready   = (state_q == S_IDLE);
      o_rsp_valid   = (state_q == S_RESP);
      o_req_addr    = '0;
      o_req_wr_data = '0;
      o_req_wr_en   = 1'b0;
      o_req_count   = `MEM_COUNT_NONE;
      if (state_q == S_REQ && count_ok(count_q)) begin
         o_req_addr    = addr_q;
         o_req_wr_data = wdata_q;
         o_req_wr_en   = we_q;
         o_req_count   = count_q;
      end
   end

   assign o_rsp_rd_data = rdata_q;
   assign o_rsp_code    = code_q;
   assign o_timeout     = tmo_q;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Directed bench for mem_request_sequencer: a transaction-level model predicts each
// response and its cycle; a per-cycle checker compares every output against it.
`ifndef MEM_BUS_DEFS
`define MEM_BUS_DEFS
`define ADDR_W 32
`define WORD_W 32
`define MEM_COUNT_W 3
`define MEM_COUNT_NONE 3'd0
`define MEM_COUNT_BYTE 3'd1
`define MEM_COUNT_HALF 3'd2
`define MEM_COUNT_WORD 3'd3
`define MEM_CODE_W 3
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module tb_mem_request_sequencer;
   localparam int TMO = 8;

   logic        clk, reset;
   logic        i_cmd_valid, o_cmd_ready;
   logic [31:0] i_cmd_addr, i_cmd_wr_data;
   logic        i_cmd_wr_en, i_cmd_unsigned;
   logic [2:0]  i_cmd_count;
   logic [31:0] o_req_addr, o_req_wr_data;
   logic        o_req_wr_en;
   logic [2:0]  o_req_count;
   logic [31:0] i_res_rd_data;
   logic [2:0]  i_res_code;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rd_data;
   logic [2:0]  o_rsp_code;
   logic        o_timeout;

   mem_request_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_addr(i_cmd_addr), .i_cmd_wr_data(i_cmd_wr_data),
      .i_cmd_wr_en(i_cmd_wr_en), .i_cmd_count(i_cmd_count),
      .i_cmd_unsigned(i_cmd_unsigned),
      .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data),
      .o_req_wr_en(o_req_wr_en), .o_req_count(o_req_count),
      .i_res_rd_data(i_res_rd_data), .i_res_code(i_res_code),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rd_data(o_rsp_rd_data),
      .o_rsp_code(o_rsp_code), .o_timeout(o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;

   // Expectations for the transaction in flight
   int          exp_acc = -100, exp_rsp = -100, exp_req = -100;
   logic [31:0] e_addr, e_wdata, e_data, held_data = '0;
   logic        e_we, e_tmo, held_tmo = 1'b0;
   logic [2:0]  e_cnt, e_code;
   logic [31:0] got_data;
   logic [2:0]  got_code;
   logic        got_tmo;
   int          got_lat;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, got, exp);
      end
   endtask

   // Spec-level model: what the core must see for one command.
   function automatic void model(input logic [2:0] cnt, input logic uns, input logic [31:0] rd,
                                 input logic [2:0] sc, input int dly,
                                 output logic [31:0] d, output logic [2:0] c, output logic t,
                                 output int lat);
      d = '0; t = 1'b0;
      if (!(cnt inside {`MEM_COUNT_BYTE, `MEM_COUNT_HALF, `MEM_COUNT_WORD})) begin
         c = `MEM_CODE_INVALID; lat = 2;
      end else if (dly < 0 || dly >= TMO) begin
         c = `MEM_CODE_OUT_OF_BOUNDS; t = 1'b1; lat = 2 + TMO;
      end else begin
         c = sc; lat = 3 + dly;
         if (sc == `MEM_CODE_READ) begin
            case (cnt)
               `MEM_COUNT_BYTE: d = uns ? (rd & 32'hFF)   : int'($signed(rd[7:0]));
               `MEM_COUNT_HALF: d = uns ? (rd & 32'hFFFF) : int'($signed(rd[15:0]));
               default:         d = rd;
            endcase
         end
      end
   endfunction

   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         chk("cmd_ready", o_cmd_ready, !(cyc > exp_acc && cyc <= exp_rsp));
         chk("rsp_valid", o_rsp_valid, cyc == exp_rsp);
         if (cyc == exp_req) begin
            chk("req_count", o_req_count, e_cnt);
            chk("req_addr", o_req_addr, e_addr);
            chk("req_wr_data", o_req_wr_data, e_wdata);
            chk("req_wr_en", o_req_wr_en, e_we);
         end else begin
            chk("req_count_idle", o_req_count, `MEM_COUNT_NONE);
            chk("req_wr_en_idle", o_req_wr_en, 1'b0);
         end
         if (o_rsp_valid) begin
            chk("rsp_rd_data", o_rsp_rd_data, e_data);
            chk("rsp_code", o_rsp_code, e_code);
            chk("timeout", o_timeout, e_tmo);
            got_data = o_rsp_rd_data; got_code = o_rsp_code; got_tmo = o_timeout;
            got_lat = cyc - exp_acc;
            held_data = e_data; held_tmo = e_tmo;
         end else begin
            chk("rd_data_hold", o_rsp_rd_data, held_data);
            chk("timeout_hold", o_timeout, held_tmo);
         end
      end
   end

   // Issue one command at the current (idle) cycle and play the slave; dly < 0 = silent slave.
   task automatic run(input string name, input logic [31:0] addr, input logic [31:0] wd,
                      input logic we, input logic [2:0] cnt, input logic uns,
                      input logic [31:0] rd, input logic [2:0] sc, input int dly, input bit noise,
                      input logic [31:0] lit_data, input logic [2:0] lit_code,
                      input logic lit_tmo, input int lit_lat);
      int a;
      int lat;
      a = cyc;
      model(cnt, uns, rd, sc, dly, e_data, e_code, e_tmo, lat);
      e_addr = addr; e_wdata = wd; e_we = we; e_cnt = cnt;
      exp_acc = a; exp_rsp = a + lat;
      exp_req = (cnt inside {`MEM_COUNT_BYTE, `MEM_COUNT_HALF, `MEM_COUNT_WORD}) ? a + 1 : -100;
      got_lat = -1;
      i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_wr_data = wd;
      i_cmd_wr_en = we; i_cmd_count = cnt; i_cmd_unsigned = uns;
      @(negedge clk);
      i_cmd_valid = 1'b0; i_cmd_addr = 32'hFFFF_FFFF; i_cmd_wr_data = 32'h5A5A_5A5A;
      i_cmd_wr_en = ~we; i_cmd_count = `MEM_COUNT_WORD; i_cmd_unsigned = ~uns;
      i_res_code = noise ? `MEM_CODE_MISALIGNED : `MEM_CODE_INVALID;
      @(negedge clk);
      i_res_code = `MEM_CODE_INVALID;
      if (dly >= 0) begin
         while (cyc < a + 2 + dly) @(negedge clk);
         i_res_rd_data = rd; i_res_code = sc;
         @(negedge clk);
         i_res_code = `MEM_CODE_INVALID; i_res_rd_data = 32'hA5A5_A5A5;
      end
      while (cyc <= exp_rsp) @(negedge clk);
      chk({name, "_lat"}, got_lat, lit_lat);
      chk({name, "_data"}, got_data, lit_data);
      chk({name, "_code"}, got_code, lit_code);
      chk({name, "_tmo"}, got_tmo, lit_tmo);
   endtask

   initial begin
      int a;
      reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_wr_data = '0;
      i_cmd_wr_en = 1'b0; i_cmd_count = `MEM_COUNT_NONE; i_cmd_unsigned = 1'b0;
      i_res_rd_data = '0; i_res_code = `MEM_CODE_INVALID;
      repeat (3) @(negedge clk);
      chk("rst_ready", o_cmd_ready, 1'b1);
      chk("rst_valid", o_rsp_valid, 1'b0);
      chk("rst_code", o_rsp_code, `MEM_CODE_INVALID);
      chk("rst_data", o_rsp_rd_data, 32'h0);
      chk("rst_tmo", o_timeout, 1'b0);
      chk("rst_req_count", o_req_count, `MEM_COUNT_NONE);
      reset = 1'b0; chk_en = 1'b1;
      @(negedge clk);

      run("sbyte", 32'h1001, 32'h0, 1'b0, `MEM_COUNT_BYTE, 1'b0, 32'h80, `MEM_CODE_READ, 0, 1'b0,
          32'hFFFF_FF80, `MEM_CODE_READ, 1'b0, 3);
      run("uhalf", 32'h2002, 32'h0, 1'b0, `MEM_COUNT_HALF, 1'b1, 32'hF00D, `MEM_CODE_READ, 0, 1'b0,
          32'h0000_F00D, `MEM_CODE_READ, 1'b0, 3);
      run("shalf", 32'h2002, 32'h0, 1'b0, `MEM_COUNT_HALF, 1'b0, 32'hF00D, `MEM_CODE_READ, 0, 1'b0,
          32'hFFFF_F00D, `MEM_CODE_READ, 1'b0, 3);
      run("wstore", 32'h8, 32'hDEAD_BEEF, 1'b1, `MEM_COUNT_WORD, 1'b0, 32'h1234, `MEM_CODE_WRITE, 0, 1'b0,
          32'h0, `MEM_CODE_WRITE, 1'b0, 3);
      run("silent", 32'h4000, 32'h0, 1'b0, `MEM_COUNT_WORD, 1'b0, 32'h0, `MEM_CODE_INVALID, -1, 1'b0,
          32'h0, `MEM_CODE_OUT_OF_BOUNDS, 1'b1, 10);
      run("misal", 32'h2, 32'h0, 1'b0, `MEM_COUNT_WORD, 1'b0, 32'h1234, `MEM_CODE_MISALIGNED, 0, 1'b0,
          32'h0, `MEM_CODE_MISALIGNED, 1'b0, 3);
      run("cnone", 32'h10, 32'h0, 1'b0, `MEM_COUNT_NONE, 1'b0, 32'h0, `MEM_CODE_READ, -1, 1'b0,
          32'h0, `MEM_CODE_INVALID, 1'b0, 2);
      run("cundef", 32'h10, 32'h0, 1'b0, 3'd6, 1'b0, 32'h0, `MEM_CODE_READ, -1, 1'b0,
          32'h0, `MEM_CODE_INVALID, 1'b0, 2);
      run("wdelay", 32'h20, 32'h0, 1'b0, `MEM_COUNT_WORD, 1'b0, 32'h8000_0001, `MEM_CODE_READ, 3, 1'b1,
          32'h8000_0001, `MEM_CODE_READ, 1'b0, 6);
      run("lastwait", 32'h24, 32'h0, 1'b0, `MEM_COUNT_BYTE, 1'b1, 32'hFFFF_FF7F, `MEM_CODE_READ, TMO - 1, 1'b0,
          32'h0000_007F, `MEM_CODE_READ, 1'b0, 10);

      // Abort a load in WAIT with reset, then a fresh load must complete normally.
      a = cyc;
      exp_acc = a; exp_rsp = a + 100; exp_req = a + 1;
      e_addr = 32'h30; e_wdata = 32'h0; e_we = 1'b0; e_cnt = `MEM_COUNT_WORD;
      i_cmd_valid = 1'b1; i_cmd_addr = 32'h30; i_cmd_wr_data = '0; i_cmd_wr_en = 1'b0;
      i_cmd_count = `MEM_COUNT_WORD; i_cmd_unsigned = 1'b0;
      @(negedge clk);
      i_cmd_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      chk_en = 1'b0; reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_acc = -100; exp_rsp = -100; exp_req = -100;
      held_data = '0; held_tmo = 1'b0;
      chk("abort_ready", o_cmd_ready, 1'b1);
      chk("abort_code", o_rsp_code, `MEM_CODE_INVALID);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      run("postrst", 32'h1003, 32'h0, 1'b0, `MEM_COUNT_BYTE, 1'b0, 32'h7F, `MEM_CODE_READ, 1, 1'b0,
          32'h0000_007F, `MEM_CODE_READ, 1'b0, 4);
      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end
endmodule
